// File: rtl/delay_unit_arbiter.sv
// delay_unit_arbiter: two ready/valid requesters share one fixed-latency
// delay pipeline. Beats are granted round-robin, tagged with their source
// channel and returned on the matching output channel LATENCY cycles later.
// An IDLE/RUN/DRAIN sequencer lets the controller quiesce the unit cleanly.
module delay_unit_arbiter #(
    parameter int WIDTH   = 5,
    parameter int LATENCY = 3
) (
    input  logic                             CLK,
    input  logic                             RESETN,
    input  logic                             EN,
    input  logic [WIDTH-1:0]                 I_0_data,
    input  logic                             I_0_valid,
    output logic                             I_0_ready,
    input  logic [WIDTH-1:0]                 I_1_data,
    input  logic                             I_1_valid,
    output logic                             I_1_ready,
    output logic [WIDTH-1:0]                 O_0_data,
    output logic                             O_0_valid,
    input  logic                             O_0_ready,
    output logic [WIDTH-1:0]                 O_1_data,
    output logic                             O_1_valid,
    input  logic                             O_1_ready,
    output logic                             BUSY,
    output logic [$clog2(LATENCY+1)-1:0]     OCC
);

    localparam int                OCC_W   = $clog2(LATENCY + 1);
    localparam logic [OCC_W-1:0]  OCC_ONE = OCC_W'(1);
    localparam logic [OCC_W-1:0]  OCC_MAX = OCC_W'(LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic                 last;       // channel granted most recently

    // Stage i holds S(i+1); index LATENCY-1 is the head.
    logic [LATENCY-1:0]   stg_vld;
    logic [LATENCY-1:0]   stg_tag;
    logic [WIDTH-1:0]     stg_dat [LATENCY];

    logic                 head_vld;
    logic                 head_tag;
    logic [WIDTH-1:0]     head_dat;
    logic                 head_rdy;
    logic                 stall;
    logic                 out_hs;
    logic                 can_grant;
    logic                 grant_0;
    logic                 grant_1;
    logic                 accept;
    logic [WIDTH-1:0]     s1_dat;
    logic [OCC_W-1:0]     occ_next;

    assign head_vld = stg_vld[LATENCY-1];
    assign head_tag = stg_tag[LATENCY-1];
    assign head_dat = stg_dat[LATENCY-1];

    // Handshake, stall and round-robin grant; readies never feed back on themselves.
    always_comb begin
        head_rdy  = head_tag ? O_1_ready : O_0_ready;
        stall     = head_vld & ~head_rdy;
        out_hs    = head_vld & ~stall;
        can_grant = (state == RUN) & ~stall;
        grant_0   = can_grant & I_0_valid & (~I_1_valid | last);
        grant_1   = can_grant & I_1_valid & (~I_0_valid | ~last);
        accept    = grant_0 | grant_1;
        // Bubbles enter with zero data so an idle head presents clean zeros.
        s1_dat    = grant_1 ? I_1_data : (grant_0 ? I_0_data : '0);
    end

    // Occupancy bookkeeping: +1 on accept, -1 on output handshake, capped at LATENCY.
    always_comb begin
        occ_next = OCC;
        if (accept && !out_hs && (OCC != OCC_MAX)) begin
            occ_next = OCC + OCC_ONE;
        end else if (!accept && out_hs) begin
            occ_next = OCC - OCC_ONE;
        end
    end

    // Delay pipeline: shift whenever the head is not blocked, hold otherwise.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            stg_vld <= '0;
            stg_tag <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stg_dat[i] <= '0;
            end
        end else if (!stall) begin
            stg_vld[0] <= accept;
            stg_tag[0] <= grant_1;
            stg_dat[0] <= s1_dat;
            for (int i = 1; i < LATENCY; i++) begin
                stg_vld[i] <= stg_vld[i-1];
                stg_tag[i] <= stg_tag[i-1];
                stg_dat[i] <= stg_dat[i-1];
            end
        end
    end

    // Enable/drain sequencer, round-robin pointer and occupancy counter.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= IDLE;
            last  <= 1'b1;
            OCC   <= '0;
        end else begin
            OCC <= occ_next;
            if (accept) begin
                last <= grant_1;
            end
            case (state)
                IDLE:    if (EN) state <= RUN;
                RUN:     if (!EN) state <= DRAIN;
                DRAIN: begin
                    if (EN) begin
                        state <= RUN;
                    end else if (occ_next == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output steering by head tag.
    always_comb begin
        I_0_ready = grant_0;
        I_1_ready = grant_1;
        O_0_valid = head_vld & ~head_tag;
        O_1_valid = head_vld & head_tag;
        O_0_data  = head_tag ? '0 : head_dat;
        O_1_data  = head_tag ? head_dat : '0;
        BUSY      = (state != IDLE) | (|stg_vld);
    end

endmodule
